sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
- Central scheduler of the SDRAM controller inside sdram_top.
- Holds the bus for the power-up init sequencer until init_end, then grants the shared SDRAM command/address/data bus to one of three masters: auto-refresh, write-burst, read-burst.
- Generates the periodic refresh request internally.
- Muxes the granted master's command, bank, address and write-data onto the SDRAM pins.

Parameters:
- REF_CYCLES, 390, sclk cycles between refresh requests (7.8 us at 50 MHz, 8192 rows / 64 ms).
- ADDR_W, 13, SDRAM address width.
- DATA_W, 16, SDRAM data width.

Ports:
- sclk  in  1  system clock (50 MHz)
- s_rst_n  in  1  asynchronous active-low reset
- init_end  in  1  level; init sequence complete
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init
- init_addr  in  ADDR_W  init address (mode register)
- aref_en  out  1  refresh grant
- aref_end  in  1  1-cycle pulse; refresh done
- aref_cmd  in  4  refresh command
- aref_addr  in  ADDR_W  refresh address
- wr_trig  in  1  write request, level
- wr_en  out  1  write grant
- wr_end  in  1  1-cycle pulse; write burst done
- wr_cmd  in  4  write command
- wr_addr  in  ADDR_W  write address
- wr_bank  in  2  write bank
- wr_dq  in  DATA_W  write data
- wr_dq_oe  in  1  write data drive enable
- rd_trig  in  1  read request, level
- rd_en  out  1  read grant
- rd_end  in  1  1-cycle pulse; read burst done
- rd_cmd  in  4  read command
- rd_addr  in  ADDR_W  read address
- rd_bank  in  2  read bank
- aref_req  out  1  pending refresh; write/read masters finish the current burst and pulse *_end
- ref_overrun  out  1  sticky: timer expired while a refresh was still pending
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
- sdram_bank  out  2  bank to pins
- sdram_addr  out  ADDR_W  address to pins
- sdram_dq_out  out  DATA_W  data to the top-level tristate
- sdram_dq_oe  out  1  tristate enable

Behaviour:
- Clock and reset: single clock sclk; s_rst_n asynchronous, active-low.
- Reset values: state=ST_INIT, aref_en=wr_en=rd_en=0, aref_req=0, ref_overrun=0, refresh counter=0.
- States: ST_INIT, ST_ARBIT, ST_AREF, ST_WRITE, ST_READ (one-hot or binary; state register is the only mux select).
- Transitions:
  - ST_INIT -> ST_ARBIT on init_end=1.
  - ST_ARBIT: priority aref_req > wr_trig > rd_trig. Go to ST_AREF / ST_WRITE / ST_READ next cycle; stay if no request.
  - ST_AREF -> ST_ARBIT on aref_end.
  - ST_WRITE -> ST_ARBIT on wr_end.
  - ST_READ -> ST_ARBIT on rd_end.
- Grants: aref_en, wr_en, rd_en are registered and equal 1 exactly while in the matching state.
- Grant latency: request seen in ST_ARBIT at cycle N gives the grant at N+1.
- Turnaround: at least one ST_ARBIT cycle (sdram_cmd=NOP 4'b0111) between any two grants. No back-to-back grant even if *_end and a new request coincide.
- Command mux (combinational from state):
  - ST_INIT: init_cmd/init_addr, bank=0.
  - ST_AREF: aref_cmd/aref_addr, bank=0.
  - ST_WRITE: wr_*.
  - ST_READ: rd_cmd/rd_addr/rd_bank.
  - ST_ARBIT: NOP, addr=0, bank=0.
- sdram_dq_oe = wr_dq_oe only in ST_WRITE, else 0; sdram_dq_out = wr_dq.
- Refresh timer:
  - Held at 0 until init_end, then counts 0..REF_CYCLES-1 and wraps, free-running.
  - At count REF_CYCLES-1, aref_req is set.
  - aref_req clears on the ST_ARBIT->ST_AREF transition.
- Boundaries:
  - If the timer expires while aref_req is already 1, set ref_overrun (cleared only by reset); aref_req stays 1 and a single refresh is issued.
  - Timer expiry in the same cycle as the ST_ARBIT->ST_AREF transition: the clear wins this cycle, aref_req is set again on the next expiry, and ref_overrun is not set.
  - *_end arriving in a state it does not belong to is ignored.
  - wr_trig and rd_trig asserted together: write wins. The read is served after wr_end if rd_trig is still high.
  - Reset mid-burst: immediate return to ST_INIT, all grants drop asynchronously, and init must rerun.

Decomposition:
- Shared package sdram_pkg holds:
  - command constants CMD_NOP=4'b0111, CMD_PRE=4'b0010, CMD_AREF=4'b0001, CMD_MRS=4'b0000, CMD_ACT=4'b0011, CMD_WR=4'b0100, CMD_RD=4'b0101;
  - state encodings;
  - REF_CYCLES default.
- One natural sub-module, sdram_ref_timer: counter, aref_req, ref_overrun.

Test Plan:
- Reset, init_end at cycle 20 with no requests -> grants stay 0, sdram_cmd=4'b0111 in ST_ARBIT; aref_req rises 390 cycles after init_end.
- REF_CYCLES=50, wr_trig held, wr_end every 30 cycles -> aref_en within 1 cycle after the first wr_end following aref_req; at least 1 NOP cycle between wr_en falling and aref_en rising.
- wr_trig and rd_trig rise in the same cycle in ST_ARBIT -> wr_en at +1; after wr_end, one NOP cycle, then rd_en.
- In ST_WRITE, drive wr_cmd=4'b0100, wr_bank=2'b10, wr_addr=13'h0A5, wr_dq=16'h1234, wr_dq_oe=1 -> identical values on the pins; sdram_dq_oe=0 in ST_READ.
- REF_CYCLES=50, aref_end withheld for 120 cycles -> ref_overrun=1 at the second expiry; it stays 1 after aref_end.
- Deassert s_rst_n during ST_READ -> rd_en=0 asynchronously, state returns to ST_INIT, and no grant until init_end.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and refresh default.
package sdram_pkg;

    localparam int unsigned REF_CYCLES_DEF = 390;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } sdram_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer; raises aref_req each interval and flags
// an overrun when an interval expires with a refresh still outstanding.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int unsigned REF_CYCLES = REF_CYCLES_DEF
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic init_end,
    input  logic aref_start,
    output logic aref_req,
    output logic ref_overrun
);

    localparam int unsigned CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_aref_req;
    logic             r_overrun;
    logic             w_expire;

    assign w_expire = init_end && (r_cnt == CNT_W'(REF_CYCLES - 1));

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cnt <= '0;
        end else if (!init_end || w_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A refresh being granted this cycle swallows a coincident expiry.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_aref_req <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (aref_start) begin
            r_aref_req <= 1'b0;
        end else if (w_expire) begin
            if (r_aref_req) begin
                r_overrun <= 1'b1;
            end
            r_aref_req <= 1'b1;
        end
    end

    assign aref_req    = r_aref_req;
    assign ref_overrun = r_overrun;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus scheduler: holds the bus for init, then grants it to refresh,
// write or read masters and muxes the owner's command/address/data to the pins.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int unsigned REF_CYCLES = REF_CYCLES_DEF,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    output logic              aref_en,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_trig,
    output logic              wr_en,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_bank,
    input  logic [DATA_W-1:0] wr_dq,
    input  logic              wr_dq_oe,
    input  logic              rd_trig,
    output logic              rd_en,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_bank,
    output logic              aref_req,
    output logic              ref_overrun,
    output logic [3:0]        sdram_cmd,
    output logic [1:0]        sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    sdram_state_e r_state;
    logic         r_aref_en;
    logic         r_wr_en;
    logic         r_rd_en;
    logic         w_aref_req;
    logic         w_aref_start;

    assign w_aref_start = (r_state == ST_ARBIT) && w_aref_req;

    sdram_ref_timer #(
        .REF_CYCLES (REF_CYCLES)
    ) u_ref_timer (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .init_end    (init_end),
        .aref_start  (w_aref_start),
        .aref_req    (w_aref_req),
        .ref_overrun (ref_overrun)
    );

    // Every grant returns through ST_ARBIT, which guarantees a NOP turnaround.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state   <= ST_INIT;
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (init_end) begin
                        r_state <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    if (w_aref_req) begin
                        r_state   <= ST_AREF;
                        r_aref_en <= 1'b1;
                    end else if (wr_trig) begin
                        r_state <= ST_WRITE;
                        r_wr_en <= 1'b1;
                    end else if (rd_trig) begin
                        r_state <= ST_READ;
                        r_rd_en <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (aref_end) begin
                        r_state   <= ST_ARBIT;
                        r_aref_en <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        r_state <= ST_ARBIT;
                        r_wr_en <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        r_state <= ST_ARBIT;
                        r_rd_en <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_aref_en <= 1'b0;
                    r_wr_en   <= 1'b0;
                    r_rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux selected purely by the state register.
    always_comb begin
        sdram_cmd   = CMD_NOP;
        sdram_bank  = 2'b00;
        sdram_addr  = '0;
        sdram_dq_oe = 1'b0;
        case (r_state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_bank  = wr_bank;
                sdram_addr  = wr_addr;
                sdram_dq_oe = wr_dq_oe;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd = CMD_NOP;
            end
        endcase
    end

    assign sdram_dq_out = wr_dq;
    assign aref_en      = r_aref_en;
    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
    assign aref_req     = w_aref_req;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: a REF_CYCLES=50 instance for arbitration and
// refresh corner cases, plus a default-parameter instance for the 390-cycle interval.
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;

    logic          sclk = 1'b0;
    logic          s_rst_n;
    logic          init_end, init_end_d;
    logic [3:0]    init_cmd;
    logic [AW-1:0] init_addr;
    logic          aref_end;
    logic [3:0]    aref_cmd;
    logic [AW-1:0] aref_addr;
    logic          wr_trig, wr_end, wr_dq_oe;
    logic [3:0]    wr_cmd;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_bank;
    logic [DW-1:0] wr_dq;
    logic          rd_trig, rd_end;
    logic [3:0]    rd_cmd;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_bank;

    logic          aref_en, wr_en, rd_en, aref_req, ref_overrun, sdram_dq_oe;
    logic [3:0]    sdram_cmd;
    logic [1:0]    sdram_bank;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_dq_out;

    logic          d_aref_en, d_wr_en, d_rd_en, d_aref_req, d_overrun, d_dq_oe;
    logic [3:0]    d_cmd;
    logic [1:0]    d_bank;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_dq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    always #10 sclk = ~sclk;

    sdram_arbit #(.REF_CYCLES(50), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_trig(wr_trig), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd),
        .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
        .rd_trig(rd_trig), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd),
        .rd_addr(rd_addr), .rd_bank(rd_bank),
        .aref_req(aref_req), .ref_overrun(ref_overrun),
        .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    sdram_arbit u_dflt (
        .sclk(sclk), .s_rst_n(s_rst_n), .init_end(init_end_d),
        .init_cmd(CMD_MRS), .init_addr('0),
        .aref_en(d_aref_en), .aref_end(1'b0), .aref_cmd(CMD_AREF), .aref_addr('0),
        .wr_trig(1'b0), .wr_en(d_wr_en), .wr_end(1'b0), .wr_cmd(CMD_WR),
        .wr_addr('0), .wr_bank(2'b00), .wr_dq('0), .wr_dq_oe(1'b0),
        .rd_trig(1'b0), .rd_en(d_rd_en), .rd_end(1'b0), .rd_cmd(CMD_RD),
        .rd_addr('0), .rd_bank(2'b00),
        .aref_req(d_aref_req), .ref_overrun(d_overrun),
        .sdram_cmd(d_cmd), .sdram_bank(d_bank), .sdram_addr(d_addr),
        .sdram_dq_out(d_dq), .sdram_dq_oe(d_dq_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
        cyc_n++;
    endtask

    task automatic run_to(input int n);
        while (cyc_n < n) step();
    endtask

    initial begin
        s_rst_n    = 1'b0;
        init_end   = 1'b0;
        init_end_d = 1'b0;
        init_cmd   = CMD_MRS;
        init_addr  = 13'h0232;
        aref_end   = 1'b0;
        aref_cmd   = CMD_AREF;
        aref_addr  = 13'h0400;
        wr_trig    = 1'b0;
        wr_end     = 1'b0;
        wr_cmd     = CMD_WR;
        wr_addr    = 13'h00A5;
        wr_bank    = 2'b10;
        wr_dq      = 16'h1234;
        wr_dq_oe   = 1'b1;
        rd_trig    = 1'b0;
        rd_end     = 1'b0;
        rd_cmd     = CMD_RD;
        rd_addr    = 13'h0155;
        rd_bank    = 2'b01;

        run_to(3);
        chk("rst_grants", {29'd0, aref_en, wr_en, rd_en}, 32'd0);
        chk("rst_req",    {30'd0, aref_req, ref_overrun}, 32'd0);
        s_rst_n = 1'b1;
        run_to(20);
        chk("init_cmd",  sdram_cmd, CMD_MRS);
        chk("init_addr", sdram_addr, 13'h0232);
        chk("init_bank", sdram_bank, 2'b00);
        chk("init_oe",   sdram_dq_oe, 1'b0);

        // Default instance: 390-cycle refresh interval, idle NOP in ST_ARBIT.
        init_end_d = 1'b1;
        cyc_n = 0;
        run_to(1);
        chk("dflt_nop",    d_cmd, CMD_NOP);
        chk("dflt_grants", {29'd0, d_aref_en, d_wr_en, d_rd_en}, 32'd0);
        run_to(389);
        chk("dflt_req_389", d_aref_req, 1'b0);
        chk("dflt_nop_389", d_cmd, CMD_NOP);
        run_to(390);
        chk("dflt_req_390", d_aref_req, 1'b1);
        chk("dflt_en_390",  d_aref_en, 1'b0);
        run_to(391);
        chk("dflt_aref_en", d_aref_en, 1'b1);
        chk("dflt_aref_cmd", d_cmd, CMD_AREF);

        // REF_CYCLES=50 instance: expiries at cycles 50,100,150,200,250.
        init_end = 1'b1;
        cyc_n = 0;
        run_to(1);
        chk("arb_nop",  sdram_cmd, CMD_NOP);
        chk("arb_addr", sdram_addr, 13'h0000);
        run_to(2);
        wr_trig = 1'b1;
        rd_trig = 1'b1;
        run_to(3);
        chk("wr_first",  {30'd0, wr_en, rd_en}, 32'b10);
        chk("wr_cmd",    sdram_cmd, CMD_WR);
        chk("wr_bank",   sdram_bank, 2'b10);
        chk("wr_addr",   sdram_addr, 13'h00A5);
        chk("wr_dq",     sdram_dq_out, 16'h1234);
        chk("wr_dq_oe",  sdram_dq_oe, 1'b1);
        run_to(10);
        wr_end  = 1'b1;
        wr_trig = 1'b0;
        run_to(11);
        wr_end = 1'b0;
        chk("turn_nop",    sdram_cmd, CMD_NOP);
        chk("turn_grants", {29'd0, aref_en, wr_en, rd_en}, 32'd0);
        run_to(12);
        chk("rd_after_wr", rd_en, 1'b1);
        chk("rd_cmd",      sdram_cmd, CMD_RD);
        chk("rd_bank",     sdram_bank, 2'b01);
        chk("rd_addr",     sdram_addr, 13'h0155);
        chk("rd_dq_oe",    sdram_dq_oe, 1'b0);
        run_to(13);
        wr_end = 1'b1;
        run_to(14);
        wr_end = 1'b0;
        chk("stray_wr_end", rd_en, 1'b1);
        run_to(15);
        rd_end  = 1'b1;
        rd_trig = 1'b0;
        run_to(16);
        rd_end = 1'b0;
        chk("rd_release", rd_en, 1'b0);

        // Refresh requested mid-write waits for wr_end, then a NOP, then aref_en.
        run_to(40);
        wr_trig = 1'b1;
        run_to(49);
        chk("req_pre", aref_req, 1'b0);
        run_to(50);
        chk("req_set",      aref_req, 1'b1);
        chk("wr_hold",      {30'd0, wr_en, aref_en}, 32'b10);
        run_to(60);
        wr_end = 1'b1;
        run_to(61);
        wr_end = 1'b0;
        chk("aref_turn_nop", sdram_cmd, CMD_NOP);
        chk("aref_turn_gnt", {29'd0, aref_en, wr_en, rd_en}, 32'd0);
        run_to(62);
        chk("aref_grant", {29'd0, aref_en, wr_en, rd_en}, 32'b100);
        chk("aref_cmd",   sdram_cmd, CMD_AREF);
        chk("aref_addr",  sdram_addr, 13'h0400);
        chk("req_clear",  aref_req, 1'b0);
        run_to(65);
        aref_end = 1'b1;
        run_to(66);
        aref_end = 1'b0;
        run_to(67);
        chk("wr_resume", wr_en, 1'b1);

        // Grant coinciding with expiry: clear wins, no overrun.
        run_to(148);
        wr_end = 1'b1;
        run_to(149);
        wr_end = 1'b0;
        chk("coinc_req_pre", aref_req, 1'b1);
        run_to(150);
        chk("coinc_grant", aref_en, 1'b1);
        chk("coinc_req",   aref_req, 1'b0);
        chk("coinc_ovr",   ref_overrun, 1'b0);
        run_to(199);
        chk("coinc_req_199", aref_req, 1'b0);
        run_to(200);
        chk("coinc_req_200", aref_req, 1'b1);

        // aref_end withheld: next expiry with req pending sets sticky overrun.
        run_to(249);
        chk("ovr_pre", ref_overrun, 1'b0);
        run_to(250);
        chk("ovr_set", ref_overrun, 1'b1);
        chk("ovr_req", aref_req, 1'b1);
        chk("ovr_hold_en", aref_en, 1'b1);
        run_to(255);
        aref_end = 1'b1;
        run_to(256);
        aref_end = 1'b0;
        chk("ovr_turn", aref_en, 1'b0);
        run_to(257);
        chk("ovr_single_aref", aref_en, 1'b1);
        chk("ovr_sticky",      ref_overrun, 1'b1);
        chk("ovr_req_clr",     aref_req, 1'b0);
        run_to(260);
        aref_end = 1'b1;
        wr_trig  = 1'b0;
        rd_trig  = 1'b1;
        run_to(261);
        aref_end = 1'b0;
        run_to(262);
        chk("rd_grant2", rd_en, 1'b1);

        // Asynchronous reset in ST_READ; no grant until init reruns.
        run_to(265);
        #5;
        s_rst_n  = 1'b0;
        init_end = 1'b0;
        #1;
        chk("arst_rd_en", rd_en, 1'b0);
        chk("arst_ovr",   ref_overrun, 1'b0);
        chk("arst_cmd",   sdram_cmd, CMD_MRS);
        #2;
        s_rst_n = 1'b1;
        run_to(275);
        chk("arst_no_grant", {29'd0, aref_en, wr_en, rd_en}, 32'd0);
        chk("arst_init_cmd", sdram_cmd, CMD_MRS);
        init_end = 1'b1;
        run_to(276);
        chk("reinit_nop", sdram_cmd, CMD_NOP);
        chk("reinit_rd0", rd_en, 1'b0);
        run_to(277);
        chk("reinit_rd1", rd_en, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
